// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - initiator for the 8-bit ALU handshake with a response FIFO
//
// Purpose:
//   Accepts one host command at a time, presents it to the ALU for one ISSUE
//   cycle, then waits for alu_result_ready or a timeout. Each finished operation
//   pushes {timeout, flags, data} into a DEPTH-entry response FIFO that the host
//   drains. A command is accepted only while the FIFO has room, so the single
//   outstanding operation can never overflow it.
//
// Configuration macro:
//   ALU_ISSUER_CHAIN_EN - carry/borrow come from internal chain registers that
//   follow ADD/CADD and SUB/BSUB results instead of cmd_cin/cmd_bin.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready            host command handshake
//   cmd_opcode/cmd_a/cmd_b         opcode and operands
//   cmd_cin/cmd_bin                carry/borrow in (ignored when chaining)
//   alu_opcode/alu_operand_A/B     held ALU request fields
//   alu_enable/alu_input_ready     one-cycle issue strobe
//   alu_carry_in/alu_borrow_in     carry/borrow to the ALU
//   alu_y_out/alu_flags            ALU result and flags
//   alu_result_ready               ALU completion
//   rsp_valid/rsp_ready            response FIFO head handshake
//   rsp_data/rsp_flags             head entry {timeout, flags}, data
//   busy                           operation in flight
module alu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [4:0] cmd_opcode,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_cin,
  input  logic       cmd_bin,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_operand_A,
  output logic [7:0] alu_operand_B,
  output logic       alu_enable,
  output logic       alu_input_ready,
  output logic       alu_carry_in,
  output logic       alu_borrow_in,
  input  logic [7:0] alu_y_out,
  input  logic       alu_result_ready,
  input  logic [5:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [6:0] rsp_flags,
  output logic       busy
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE  = 1;
  localparam logic [AW-1:0]  PTR_ONE  = 1;
  localparam logic [7:0]     TO_LAST  = 8'(TIMEOUT - 1);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_CADD = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_BSUB = 5'd3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [7:0]    wait_cnt_q, wait_cnt_d;
  logic [4:0]    op_q;
  logic [7:0]    a_q, b_q;
  logic [14:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic          accept, push, push_to, pop;
  logic [14:0]   push_entry;

  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    accept          = 1'b0;
    push            = 1'b0;
    push_to         = 1'b0;
    cmd_ready       = 1'b0;
    alu_enable      = 1'b0;
    alu_input_ready = 1'b0;
    busy            = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = (count_q < CNT_FULL);
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // result_ready is not looked at here: any level now belongs to the previous op
        alu_enable      = 1'b1;
        alu_input_ready = 1'b1;
        busy            = 1'b1;
        wait_cnt_d      = 8'd0;
        state_d         = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (alu_result_ready) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt_q == TO_LAST) begin
          push    = 1'b1;
          push_to = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign push_entry = push_to ? {7'b1000000, 8'h00} : {1'b0, alu_flags, alu_y_out};
  assign rsp_valid  = (count_q != '0);
  assign pop        = rsp_valid && rsp_ready;
  assign rsp_data   = mem_q[rd_ptr_q][7:0];
  assign rsp_flags  = mem_q[rd_ptr_q][14:8];

  assign alu_opcode    = op_q;
  assign alu_operand_A = a_q;
  assign alu_operand_B = b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 8'd0;
      op_q       <= 5'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        op_q <= cmd_opcode;
        a_q  <= cmd_a;
        b_q  <= cmd_b;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef ALU_ISSUER_CHAIN_EN
  logic chain_c_q, chain_b_q;
  logic unused_cmd_carry;

  assign unused_cmd_carry = cmd_cin ^ cmd_bin;

  // Chain registers only move on the push that ends an op, so the ALU sees a
  // stable carry/borrow for the whole ISSUE..WAIT window of the next op.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_c_q <= 1'b0;
      chain_b_q <= 1'b0;
    end else if (push) begin
      if (push_to) begin
        chain_c_q <= 1'b0;
        chain_b_q <= 1'b0;
      end else begin
        case (op_q)
          OP_ADD, OP_CADD: chain_c_q <= alu_flags[0];
          OP_SUB, OP_BSUB: chain_b_q <= alu_flags[1];
          default: begin
            chain_c_q <= 1'b0;
            chain_b_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign alu_carry_in  = chain_c_q;
  assign alu_borrow_in = chain_b_q;
`else
  logic cin_q, bin_q;
  logic [4:0] unused_op_codes;

  assign unused_op_codes = OP_ADD ^ OP_CADD ^ OP_SUB ^ OP_BSUB;

  always_ff @(posedge clk) begin
    if (rst) begin
      cin_q <= 1'b0;
      bin_q <= 1'b0;
    end else if (accept) begin
      cin_q <= cmd_cin;
      bin_q <= cmd_bin;
    end
  end

  assign alu_carry_in  = cin_q;
  assign alu_borrow_in = bin_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - self-checking bench for alu_cmd_issuer
module tb_alu_cmd_issuer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_opcode = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_cin = 1'b0;
  logic       cmd_bin = 1'b0;
  logic [4:0] alu_opcode;
  logic [7:0] alu_operand_A, alu_operand_B;
  logic       alu_enable, alu_input_ready, alu_carry_in, alu_borrow_in;
  logic [7:0] alu_y_out;
  logic       alu_result_ready;
  logic [5:0] alu_flags;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [6:0] rsp_flags;
  logic       busy;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_bin(cmd_bin),
    .alu_opcode(alu_opcode), .alu_operand_A(alu_operand_A), .alu_operand_B(alu_operand_B),
    .alu_enable(alu_enable), .alu_input_ready(alu_input_ready),
    .alu_carry_in(alu_carry_in), .alu_borrow_in(alu_borrow_in),
    .alu_y_out(alu_y_out), .alu_result_ready(alu_result_ready), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ALU behaviour: {parity, overflow, negative, zero, borrow_out, carry_out, y}
  function automatic logic [13:0] alu_calc(input logic [4:0] op, input logic [7:0] a,
                                           input logic [7:0] b, input logic ci, input logic bi);
    int r;
    logic [7:0] y;
    logic c, bo, ov;
    c = 1'b0; bo = 1'b0; ov = 1'b0;
    if (op == 5'd0 || op == 5'd1) begin
      r  = int'(a) + int'(b) + ((op == 5'd1) ? int'(ci) : 0);
      y  = r[7:0];
      c  = (r > 255);
      ov = (a[7] == b[7]) && (y[7] != a[7]);
    end else if (op == 5'd2 || op == 5'd3) begin
      r  = int'(a) - int'(b) - ((op == 5'd3) ? int'(bi) : 0);
      y  = r[7:0];
      bo = (r < 0);
      ov = (a[7] != b[7]) && (y[7] != a[7]);
    end else begin
      y = a ^ b ^ {3'b000, op};
    end
    return {^y, ov, y[7], (y == 8'h00), bo, c, y};
  endfunction

  // ALU model: responds issue_lat cycles after the issue strobe (0 = never)
  int         issue_lat = 1;
  logic       armed = 1'b0;
  int         left = 0;
  logic       rr_force = 1'b0;
  logic [4:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0;
  logic       m_ci = 1'b0, m_bi = 1'b0;
  logic [13:0] m_res;

  always @(posedge clk) begin
    if (alu_enable === 1'b1) begin
      armed <= (issue_lat != 0);
      left  <= issue_lat - 1;
      m_op  <= alu_opcode;
      m_a   <= alu_operand_A;
      m_b   <= alu_operand_B;
      m_ci  <= alu_carry_in;
      m_bi  <= alu_borrow_in;
    end else if (armed) begin
      if (left == 0) armed <= 1'b0;
      else left <= left - 1;
    end
  end

  assign m_res            = alu_calc(m_op, m_a, m_b, m_ci, m_bi);
  assign alu_y_out        = m_res[7:0];
  assign alu_flags        = m_res[13:8];
  assign alu_result_ready = (armed && left == 0) || rr_force;

  // Reference model: every accepted command becomes one entry, visible from its push edge
  typedef struct {
    logic [4:0]  op;
    logic [7:0]  a, b;
    logic        ci, bi;
    int          acc, push;
    logic [14:0] rsp;
  } ent_t;

  ent_t q[$];
  int   now = 0;
  int   cur_lat = 1;
  bit   last_fire = 0;
  logic m_chain_c = 1'b0, m_chain_b = 1'b0;

  task automatic check_cycle(output bit cr_e, output bit rv_e);
    bit busy_e, en_e;
    rv_e   = (q.size() > 0) && (q[0].push <= now);
    busy_e = (q.size() > 0) && (q[$].push > now);
    cr_e   = !busy_e && (q.size() < DEPTH);
    en_e   = busy_e && (q[$].acc == now);
    chk("rsp_valid", rsp_valid, rv_e);
    chk("cmd_ready", cmd_ready, cr_e);
    chk("busy", busy, busy_e);
    chk("alu_enable", alu_enable, en_e);
    chk("alu_input_ready", alu_input_ready, en_e);
    if (rv_e) begin
      chk("rsp_data", rsp_data, q[0].rsp[7:0]);
      chk("rsp_flags", rsp_flags, q[0].rsp[14:8]);
    end
    if (busy_e) begin
      chk("alu_opcode", alu_opcode, q[$].op);
      chk("alu_operand_A", alu_operand_A, q[$].a);
      chk("alu_operand_B", alu_operand_B, q[$].b);
      chk("alu_carry_in", alu_carry_in, q[$].ci);
      chk("alu_borrow_in", alu_borrow_in, q[$].bi);
    end
  endtask

  task automatic cyc();
    ent_t e;
    bit cr_e, rv_e, fire, timed_out;
    int eff;
    logic [13:0] res;
    check_cycle(cr_e, rv_e);
    fire = cmd_valid && cr_e;
    if (rsp_ready && rv_e) void'(q.pop_front());
    if (fire) begin
      e.op = cmd_opcode; e.a = cmd_a; e.b = cmd_b;
`ifdef ALU_ISSUER_CHAIN_EN
      e.ci = m_chain_c; e.bi = m_chain_b;
`else
      e.ci = cmd_cin; e.bi = cmd_bin;
`endif
      timed_out = !(cur_lat >= 1 && cur_lat <= TIMEOUT);
      eff = timed_out ? TIMEOUT : cur_lat;
      res = alu_calc(e.op, e.a, e.b, e.ci, e.bi);
      e.rsp = timed_out ? 15'h4000 : {1'b0, res};
      if (timed_out) begin
        m_chain_c = 1'b0; m_chain_b = 1'b0;
      end else if (e.op == 5'd0 || e.op == 5'd1) begin
        m_chain_c = res[8];
      end else if (e.op == 5'd2 || e.op == 5'd3) begin
        m_chain_b = res[9];
      end else begin
        m_chain_c = 1'b0; m_chain_b = 1'b0;
      end
    end
    @(posedge clk);
    now++;
    if (fire) begin
      e.acc  = now;
      e.push = now + 1 + eff;
      q.push_back(e);
      issue_lat = cur_lat;
    end
    last_fire = fire;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drive(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic bi, input int lat);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    cmd_cin = ci; cmd_bin = bi; cur_lat = lat;
  endtask

  task automatic send(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic bi, input int lat);
    drive(op, a, b, ci, bi, lat);
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (last_fire) break;
    end
    chk("send_accepted", last_fire, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(30);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int t;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_alu_input_ready", alu_input_ready, 0);
    chk("rst_alu_opcode", alu_opcode, 0);
    chk("rst_alu_operand_A", alu_operand_A, 0);
    chk("rst_alu_carry_in", alu_carry_in, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    rst = 1'b0;

    // 1: ADD 0x10+0x22, ALU answers one cycle after ISSUE
    send(5'd0, 8'h10, 8'h22, 1'b0, 1'b0, 1);
    cyc();
    chk("t1_rsp_valid_before_push", rsp_valid, 0);
    cyc();
    chk("t1_rsp_valid_after_push", rsp_valid, 1);
    chk("t1_rsp_data", rsp_data, 8'h32);
    chk("t1_timeout_flag", rsp_flags[6], 0);
    drain();

    // 2: ALU never answers -> timeout entry after TIMEOUT wait cycles
    send(5'd4, 8'h55, 8'h0F, 1'b0, 1'b0, 0);
    t = now;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (busy !== 1'b1) break;
    end
    chk("t2_busy_span", now - t, 1 + TIMEOUT);
    chk("t2_rsp_data", rsp_data, 8'h00);
    chk("t2_rsp_flags", rsp_flags, 7'h40);
    t = now;
    send(5'd5, 8'h01, 8'h02, 1'b0, 1'b0, 2);
    chk("t2_next_accept_delay", now - t, 1);
    drain();

    // stale result_ready during ISSUE must not complete the op
    send(5'd6, 8'hA5, 8'h3C, 1'b0, 1'b0, 0);
    rr_force = 1'b1;
    cyc();
    rr_force = 1'b0;
    idle(TIMEOUT + 1);
    chk("stale_rr_timeout_flags", rsp_flags, 7'h40);
    drain();

    // 3: FIFO fills with rsp_ready low, fifth command waits for one pop
    for (int k = 0; k < 4; k++) send(5'd0, 8'(k * 16 + 1), 8'(k + 2), 1'b0, 1'b0, 1 + k);
    drive(5'd0, 8'h77, 8'h11, 1'b0, 1'b0, 1);
    idle(12);
    chk("t3_cmd_ready_full", cmd_ready, 0);
    chk("t3_rsp_valid_full", rsp_valid, 1);
    chk("t3_head_first", rsp_data, 8'h03);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("t3_cmd_ready_after_pop", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    chk("t3_fifth_busy", busy, 1);
    drain();

    // 4: one queued entry, pop in the same edge as a push
    send(5'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1);
    idle(3);
    send(5'd0, 8'h40, 8'h05, 1'b0, 1'b0, 1);
    cyc();
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("t4_rsp_valid", rsp_valid, 1);
    chk("t4_head_is_new", rsp_data, 8'h45);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    chk("t4_empty_after_one_pop", rsp_valid, 0);

    // 5: multi-byte add via carry
    send(5'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1);
    idle(3);
    send(5'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1);
`ifdef ALU_ISSUER_CHAIN_EN
    chk("t5_carry_in", alu_carry_in, 1);
`else
    chk("t5_carry_in", alu_carry_in, 0);
`endif
    idle(2);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
`ifdef ALU_ISSUER_CHAIN_EN
    chk("t5_cadd_result", rsp_data, 8'h01);
`else
    chk("t5_cadd_result", rsp_data, 8'h00);
`endif
    drain();

    // 6: reset mid-WAIT with entries queued; late result_ready is ignored
    send(5'd0, 8'h21, 8'h21, 1'b0, 1'b0, 1);
    send(5'd2, 8'h30, 8'h10, 1'b0, 1'b1, 1);
    send(5'd3, 8'h12, 8'h34, 1'b1, 1'b1, 10);
    idle(3);
    rst = 1'b1;
    cyc();
    q.delete();
    m_chain_c = 1'b0;
    m_chain_b = 1'b0;
    chk("t6_busy", busy, 0);
    chk("t6_alu_enable", alu_enable, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    chk("t6_rsp_flags", rsp_flags, 0);
    rst = 1'b0;
    idle(15);
    chk("t6_late_result_dropped", rsp_valid, 0);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      cmd_valid  = ($urandom_range(0, 3) != 0);
      cmd_opcode = 5'($urandom_range(0, 19));
      cmd_a      = 8'($urandom);
      cmd_b      = 8'($urandom);
      cmd_cin    = 1'($urandom);
      cmd_bin    = 1'($urandom);
      rsp_ready  = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r < 6)       cur_lat = $urandom_range(1, 4);
      else if (r == 6) cur_lat = TIMEOUT;
      else if (r == 7) cur_lat = TIMEOUT + 1;
      else if (r == 8) cur_lat = 0;
      else             cur_lat = $urandom_range(5, TIMEOUT - 1);
      cyc();
    end
    drain();
    chk("final_empty", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
